mask_to_index_encoder: RTL

//   Serialising encoder: accepts an N-bit multi-hot vector, emits the index of each set bit,
//   one code per handshake beat, in priority order. Inverse of the one-hot decoders: for any

---
 rtl/mask_to_index_encoder_if.sv | 37 +++
 rtl/mask_to_index_encoder.sv | 87 ++++++++
 2 files changed

// File: rtl/mask_to_index_encoder_if.sv
// Handshake bundle for mask_to_index_encoder: vector input side and code output side.
// The slave modport is the encoder; the master modport is the surrounding source/sink.
interface mask_to_index_encoder_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_vec;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_code;
    logic         out_last;
    logic         zero_drop;

    modport master (
        output in_valid,
        output in_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_code,
        input  out_last,
        input  zero_drop
    );

    modport slave (
        input  in_valid,
        input  in_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_code,
        output out_last,
        output zero_drop
    );
endinterface

// File: rtl/mask_to_index_encoder.sv
// Serialising encoder: takes a multi-hot vector and emits the index of each set bit,
// one code per output handshake, lowest-first or highest-first.
module mask_to_index_encoder #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = 3,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    mask_to_index_encoder_if.slave bus
);
    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] mask_q, mask_d;
    logic         zero_drop_q, zero_drop_d;

    logic [W-1:0] sel_code;
    logic [N-1:0] sel_bit;
    logic         single;
    logic         accept;

    // Priority select over the not-yet-emitted bits; the scan direction makes the
    // last match win, so it lands on the lowest or highest set bit as configured.
    always_comb begin
        sel_code = '0;
        if (LSB_FIRST) begin
            for (int unsigned i = N; i > 0; i--) begin
                if (mask_q[i-1]) sel_code = W'(i - 1);
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (mask_q[i]) sel_code = W'(i);
            end
        end
    end

    assign sel_bit = N'(1) << sel_code;
    assign single  = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);
    assign accept  = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_code  = sel_code;
    assign bus.out_last  = single;
    assign bus.zero_drop = zero_drop_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        zero_drop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_vec != '0) begin
                        mask_d  = bus.in_vec;
                        state_d = EMIT;
                    end else begin
                        zero_drop_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    mask_d = mask_q & ~sel_bit;
                    if (single) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            zero_drop_q <= zero_drop_d;
        end
    end
endmodule
